// File: rtl/snake_segment_ring_if.sv
// rtl/snake_segment_ring_if.sv - game-control and renderer read bundle for snake_segment_ring
interface snake_segment_ring_if #(
   parameter int COORD_BIT        = 7,
   parameter int SNAKE_LENGTH_BIT = 6
);
   logic                        game_tik;
   logic [1:0]                  dir;
   logic                        grow;
   logic [SNAKE_LENGTH_BIT-1:0] rd_index;
   logic [COORD_BIT-1:0]        rd_x;
   logic [COORD_BIT-1:0]        rd_y;
   logic                        rd_valid;
   logic [COORD_BIT-1:0]        snake_head_x;
   logic [COORD_BIT-1:0]        snake_head_y;
   logic [SNAKE_LENGTH_BIT-1:0] snake_length;
   logic                        busy;
   logic                        game_over;

   modport master (
      output game_tik, dir, grow, rd_index,
      input  rd_x, rd_y, rd_valid, snake_head_x, snake_head_y, snake_length, busy, game_over
   );

   modport slave (
      input  game_tik, dir, grow, rd_index,
      output rd_x, rd_y, rd_valid, snake_head_x, snake_head_y, snake_length, busy, game_over
   );
endinterface

// File: rtl/snake_segment_ring.sv
// rtl/snake_segment_ring.sv - snake body ring buffer with motion, growth and collision scan
// Optional macro WRAP_EDGES_EN: the head wraps across grid edges instead of dying at walls.
module snake_segment_ring #(
   parameter int COORD_BIT        = 7,
   parameter int SNAKE_LENGTH_BIT = 6,
   parameter int MAX_LENGTH       = 40,
   parameter int INIT_LENGTH      = 3,
   parameter int INIT_X           = 20,
   parameter int INIT_Y           = 15,
   parameter int GRID_W           = 80,
   parameter int GRID_H           = 60
) (
   input  logic                clock_25,
   input  logic                reset,
   input  logic                sync_reset,
   snake_segment_ring_if.slave bus
);
   localparam int LW  = SNAKE_LENGTH_BIT;
   localparam int LW1 = SNAKE_LENGTH_BIT + 1;
   localparam logic [LW:0] MAX_W = LW1'(MAX_LENGTH);

   typedef logic [LW-1:0]        idx_t;
   typedef logic [COORD_BIT-1:0] crd_t;
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_MOVE, S_SCAN, S_DEAD} state_t;

   state_t     state_q, state_d;
   idx_t       head_ptr_q, head_ptr_d, len_q, len_d, cnt_q, cnt_d;
   logic [1:0] dir_q, dir_d;
   logic       grow_q, grow_d, over_q, over_d;
   crd_t       head_x_q, head_x_d, head_y_q, head_y_d;
   crd_t       rd_x_q, rd_x_d, rd_y_q, rd_y_d;
   logic       rd_valid_q, rd_valid_d;

   crd_t mem_x [MAX_LENGTH];
   crd_t mem_y [MAX_LENGTH];

   logic rst, wr_en, wall, hit;
   idx_t wr_slot, prev_ptr, scan_slot, rd_slot;
   crd_t wr_x, wr_y, nx, ny;

   function automatic idx_t slot_of(idx_t base, idx_t off);
      logic [LW:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= MAX_W) s = s - MAX_W;
      return s[LW-1:0];
   endfunction

   assign rst       = reset | sync_reset;
   assign prev_ptr  = (head_ptr_q == '0) ? idx_t'(MAX_LENGTH - 1) : head_ptr_q - idx_t'(1);
   assign scan_slot = slot_of(head_ptr_q, cnt_q);
   assign rd_slot   = slot_of(head_ptr_q, bus.rd_index);

   // Candidate head always carries the wrapped coordinate; wall flags the edge crossing.
   always_comb begin
      nx   = head_x_q;
      ny   = head_y_q;
      wall = 1'b0;
      case (dir_q)
         2'b00: begin
            wall = (head_y_q == '0);
            ny   = wall ? crd_t'(GRID_H - 1) : head_y_q - crd_t'(1);
         end
         2'b01: begin
            wall = (head_x_q == crd_t'(GRID_W - 1));
            nx   = wall ? '0 : head_x_q + crd_t'(1);
         end
         2'b10: begin
            wall = (head_y_q == crd_t'(GRID_H - 1));
            ny   = wall ? '0 : head_y_q + crd_t'(1);
         end
         default: begin
            wall = (head_x_q == '0);
            nx   = wall ? crd_t'(GRID_W - 1) : head_x_q - crd_t'(1);
         end
      endcase
   end

`ifdef WRAP_EDGES_EN
   assign hit = 1'b0;
`else
   assign hit = wall;
`endif

   always_comb begin
      state_d    = state_q;
      head_ptr_d = head_ptr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      grow_d     = grow_q;
      over_d     = over_q;
      head_x_d   = head_x_q;
      head_y_d   = head_y_q;
      wr_en      = 1'b0;
      wr_slot    = head_ptr_q;
      wr_x       = head_x_q;
      wr_y       = head_y_q;
      if (bus.grow && state_q != S_INIT && state_q != S_DEAD) grow_d = 1'b1;
      case (state_q)
         S_INIT: begin
            wr_en   = 1'b1;
            wr_slot = cnt_q;
            wr_x    = crd_t'(INIT_X) - crd_t'(cnt_q);
            wr_y    = crd_t'(INIT_Y);
            if (cnt_q == idx_t'(INIT_LENGTH - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + idx_t'(1);
            end
         end
         S_IDLE: begin
            if (bus.game_tik) begin
               if (bus.dir != (dir_q ^ 2'b10)) dir_d = bus.dir;
               state_d = S_MOVE;
            end
         end
         S_MOVE: begin
            // The pending grow is consumed here; a pulse arriving now belongs to the next step.
            grow_d = bus.grow;
            if (hit) begin
               over_d  = 1'b1;
               state_d = S_DEAD;
            end else begin
               wr_en      = 1'b1;
               wr_slot    = prev_ptr;
               wr_x       = nx;
               wr_y       = ny;
               head_ptr_d = prev_ptr;
               head_x_d   = nx;
               head_y_d   = ny;
               if (grow_q && LW1'(len_q) < MAX_W) len_d = len_q + idx_t'(1);
               cnt_d   = idx_t'(1);
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (mem_x[scan_slot] == head_x_q && mem_y[scan_slot] == head_y_q) begin
               over_d  = 1'b1;
               state_d = S_DEAD;
            end else if (cnt_q == len_q - idx_t'(1)) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + idx_t'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_valid_d = (bus.rd_index < len_q);
      rd_x_d     = '0;
      rd_y_d     = '0;
      if (rd_valid_d) begin
         rd_x_d = mem_x[rd_slot];
         rd_y_d = mem_y[rd_slot];
      end
   end

   always_ff @(posedge clock_25) begin
      if (rst) begin
         state_q    <= S_INIT;
         head_ptr_q <= '0;
         len_q      <= idx_t'(INIT_LENGTH);
         cnt_q      <= '0;
         dir_q      <= 2'b01;
         grow_q     <= 1'b0;
         over_q     <= 1'b0;
         head_x_q   <= crd_t'(INIT_X);
         head_y_q   <= crd_t'(INIT_Y);
         rd_x_q     <= '0;
         rd_y_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_ptr_q <= head_ptr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         grow_q     <= grow_d;
         over_q     <= over_d;
         head_x_q   <= head_x_d;
         head_y_q   <= head_y_d;
         rd_x_q     <= rd_x_d;
         rd_y_q     <= rd_y_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clock_25) begin
      if (wr_en && !rst) begin
         mem_x[wr_slot] <= wr_x;
         mem_y[wr_slot] <= wr_y;
      end
   end

   assign bus.rd_x         = rd_x_q;
   assign bus.rd_y         = rd_y_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.snake_head_x = head_x_q;
   assign bus.snake_head_y = head_y_q;
   assign bus.snake_length = len_q;
   assign bus.busy         = (state_q == S_INIT) || (state_q == S_MOVE) || (state_q == S_SCAN);
   assign bus.game_over    = over_q;
endmodule

// File: doc/snake_segment_ring.md
Name: snake_segment_ring

Overview:
- Parametrised storage and motion engine for the snake body.
- Holds up to MAX_LENGTH segment coordinates in a circular buffer and advances the snake one cell per game_tik.
- Handles growth, self-collision and wall collision, and serves an indexed read port to the renderer.
- Sits between the game FSM (direction, grow, tik) and the graphics path (index → coordinates).

Parameters:
- COORD_BIT, 7, width of each x/y coordinate.
- SNAKE_LENGTH_BIT, 6, width of length and index signals.
- MAX_LENGTH, 40, buffer depth; must be ≤ 2**SNAKE_LENGTH_BIT.
- INIT_LENGTH, 3, length after reset or restart; must be ≥ 2.
- INIT_X, 20, initial head x.
- INIT_Y, 15, initial head y.
- GRID_W, 80, playfield width in cells.
- GRID_H, 60, playfield height in cells.

Ports:
- clock_25  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- sync_reset  in  1  synchronous game restart; same effect as reset.
- game_tik  in  1  single-cycle step request.
- dir  in  2  direction: 00 up, 01 right, 10 down, 11 left.
- grow  in  1  single-cycle grow request.
- rd_index  in  SNAKE_LENGTH_BIT  renderer read index; 0 = head.
- rd_x, rd_y  out  COORD_BIT each  coordinates at rd_index, registered.
- rd_valid  out  1  registered; high when rd_index < snake_length.
- snake_head_x, snake_head_y  out  COORD_BIT each  current head.
- snake_length  out  SNAKE_LENGTH_BIT  current length.
- busy  out  1  high in INIT, MOVE and SCAN.
- game_over  out  1  sticky collision flag.

Behaviour:
- **Storage mapping.** Logical index i lives at physical slot (head_ptr + i) mod MAX_LENGTH. A move decrements head_ptr mod MAX_LENGTH and writes the new head at the new head_ptr. The tail drops out implicitly because snake_length is unchanged.
- **FSM states:** INIT, IDLE, MOVE, SCAN, DEAD.
- **Reset / sync_reset.** Enter INIT; reset has priority over sync_reset, and both override any state. Outputs and registers:
  - head_ptr=0, snake_length=INIT_LENGTH, current direction=right, grow_pending=0.
  - game_over=0, busy=1, rd_x=rd_y=0, rd_valid=0.
  - snake_head_x=INIT_X, snake_head_y=INIT_Y.
- **INIT.** Lasts INIT_LENGTH cycles, writing segment i = (INIT_X−i, INIT_Y) one per cycle, then goes to IDLE.
- **IDLE.** busy=0. On game_tik, sample dir and go to MOVE.
  - A dir that is the opposite of the current direction is ignored; the current direction is kept.
- **MOVE (1 cycle).** Compute next head as ±1 on x or y.
  - Wall case (WRAP_EDGES_EN undefined): next x outside 0..GRID_W−1 or next y outside 0..GRID_H−1 → go to DEAD. Nothing is written and the head is unchanged.
  - Otherwise: write the new head and update snake_head_x/y.
  - If grow_pending and snake_length < MAX_LENGTH: snake_length += 1. grow_pending is cleared in either case.
  - Then go to SCAN.
- **SCAN.** Compare logical entries 1..snake_length−1 against the head, one entry per cycle.
  - On a match: stop scanning, set game_over the next cycle, go to DEAD.
  - With no match: return to IDLE after snake_length−1 cycles.
  - Step-to-ready latency = 1 + (snake_length−1) cycles.
- **DEAD.** game_over=1 and busy=0. game_tik and grow are ignored. Leave only via reset or sync_reset.
- **grow.**
  - Sets grow_pending in any state except DEAD and INIT.
  - grow in the same cycle as an accepted game_tik applies to that step.
  - Multiple grow pulses before a step still yield +1 only.
  - At snake_length == MAX_LENGTH, growth is discarded.
- **game_tik while busy.** Ignored and not queued.
- **Read port.** 1-cycle latency, independent of the scan.
  - rd_index ≥ snake_length → rd_valid=0 and rd_x=rd_y=0.
  - A read in the same cycle as a MOVE write returns pre-move data.
- **Arithmetic.** All pointer arithmetic is mod MAX_LENGTH using explicit compare-and-wrap, not a power-of-two mask.

Optional Feature:
- Macro: WRAP_EDGES_EN.
- Defined: a head leaving the grid re-enters on the opposite edge, and wall collision never occurs.
  - x: GRID_W−1 → 0 and 0 → GRID_W−1.
  - y: GRID_H−1 → 0 and 0 → GRID_H−1.
- Undefined: leaving the grid sets game_over as described in MOVE.

Test Plan:
- Reset, wait 3 cycles → busy=0, snake_length=3, head=(20,15); rd_index=2 → rd_x=18, rd_y=15, rd_valid=1; rd_index=3 → rd_valid=0.
- game_tik with dir=01, then game_tik with dir=11 (reversal) → head (21,15), then (22,15); length stays 3; busy is high for 3 cycles after each tik.
- grow plus game_tik in the same cycle with dir=10 → head (20,16), snake_length=4, rd_index=3 → (18,15); a second tik without grow → length stays 4.
- Grow to length 5, then steer down, left, up into own body → game_over=1 during scan; further tik and grow have no effect; sync_reset → length 3, head (20,15), game_over=0.
- Head at x=79 with dir=01 and game_tik: macro undefined → game_over=1 and head stays (79,y); WRAP_EDGES_EN defined → head (0,y) and game_over=0.
- Grow to MAX_LENGTH=40, then grow plus tik → snake_length stays 40; game_tik pulsed during SCAN is dropped (head moves only once).
